// File: rtl/sam_pkg.sv
// sam_pkg: shared definitions for the SAM control sequencer.
//   state_t   - 4-bit FSM state encoding (also exported on the debug port)
//   CTRL_*    - bit positions within the 22-bit datapath control word
//   OP_*      - IR[15:14] opcode values
package sam_pkg;

    typedef enum logic [3:0] {
        S_RESET_PC = 4'd0,
        S_F1       = 4'd1,
        S_F2       = 4'd2,
        S_F3       = 4'd3,
        S_F4       = 4'd4,
        S_DEC      = 4'd5,
        S_RD_REQ   = 4'd6,
        S_RD_LAT   = 4'd7,
        S_LD_ALU   = 4'd8,
        S_ADD_ALU  = 4'd9,
        S_WB       = 4'd10,
        S_ST_MBR   = 4'd11,
        S_ST_REQ   = 4'd12,
        S_FAULT    = 4'd15
    } state_t;

    localparam int CTRL_W = 22;

    localparam int CTRL_PC_ABUS   = 21;
    localparam int CTRL_IR_ABUS   = 20;
    localparam int CTRL_MBR_ABUS  = 19;
    localparam int CTRL_RBUS_AC   = 18;
    localparam int CTRL_AC_ALUA   = 17;
    localparam int CTRL_MBUS_ALUB = 16;
    localparam int CTRL_ALU_ADD   = 15;
    localparam int CTRL_ALU_PASSB = 14;
    localparam int CTRL_MAR_ADDR  = 13;
    localparam int CTRL_MBR_DATA  = 12;
    localparam int CTRL_ABUS_IR   = 11;
    localparam int CTRL_ABUS_MAR  = 10;
    localparam int CTRL_DATA_MBR  = 9;
    localparam int CTRL_RBUS_MBR  = 8;
    localparam int CTRL_MBR_MBUS  = 7;
    localparam int CTRL_PC_CLR    = 6;
    localparam int CTRL_PC_INC    = 5;
    localparam int CTRL_ABUS_PC   = 4;
    localparam int CTRL_RW        = 3;  // 1 = read
    localparam int CTRL_REQ       = 2;
    localparam int CTRL_AC_RBUS   = 1;
    localparam int CTRL_ALU_RBUS  = 0;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_BRN   = 2'b11;

endpackage

// File: rtl/sam_wait_timer.sv
// sam_wait_timer: counts consecutive mem_wait-high cycles of one memory
// access and flags the cycle in which the stall bound is reached.
//   clk, rst_n - clock, async active-low reset
//   active     - FSM is in a memory-access state (F2 / RD_REQ / ST_REQ)
//   mem_wait   - memory busy
//   expire     - combinational: this wait cycle is the last one tolerated,
//                the FSM must go to FAULT instead of holding
module sam_wait_timer #(
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_wait,
    output logic expire
);

    localparam int CW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (WAIT_TIMEOUT > 0) ? CW'(WAIT_TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt;

    // Any cycle that is not a held access ends the access, so the count
    // clears; saturation keeps a disabled timer from wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (active && mem_wait) begin
            if (cnt != '1) cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    assign expire = (WAIT_TIMEOUT != 0) && active && mem_wait && (cnt == LAST);

endmodule

// File: rtl/sam_sequencer.sv
// sam_sequencer: hardwired fetch/decode/execute control for the SAM
// accumulator datapath.
//   clk, rst_n - clock, async active-low reset
//   mem_wait   - memory busy, holds the current access
//   ir_op      - IR[15:14] opcode
//   ac_sign    - AC[15], branch condition for BRN
//   ctrl       - 22-bit datapath control word (decoded from state)
//   state      - current state encoding (debug)
//   instr_done - one-cycle pulse in the F1 following a finished instruction
//   fault      - high while in FAULT (left only by reset)
module sam_sequencer
    import sam_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_wait,
    input  logic [1:0]        ir_op,
    input  logic              ac_sign,
    output logic [CTRL_W-1:0] ctrl,
    output logic [3:0]        state,
    output logic              instr_done,
    output logic              fault
);

    state_t state_q, state_d;
    logic   in_wait;
    logic   expire;

    // Kept separate from the decode block so the timer's expire term does
    // not feed back into the process that produces its input.
    assign in_wait = (state_q == S_F2) || (state_q == S_RD_REQ) || (state_q == S_ST_REQ);

    sam_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (in_wait),
        .mem_wait (mem_wait),
        .expire   (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET_PC;
            instr_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            // RESET_PC->F1 starts the first fetch; nothing has completed.
            instr_done <= (state_d == S_F1) && (state_q != S_RESET_PC);
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        unique case (state_q)
            S_RESET_PC: begin
                ctrl[CTRL_PC_CLR] = 1'b1;
                state_d = S_F1;
            end
            S_F1: begin
                ctrl[CTRL_PC_ABUS]  = 1'b1;
                ctrl[CTRL_ABUS_MAR] = 1'b1;
                state_d = S_F2;
            end
            S_F2: begin
                ctrl[CTRL_MAR_ADDR] = 1'b1;
                ctrl[CTRL_RW]       = 1'b1;
                ctrl[CTRL_REQ]      = 1'b1;
                state_d = expire ? S_FAULT : (mem_wait ? S_F2 : S_F3);
            end
            S_F3: begin
                ctrl[CTRL_MAR_ADDR] = 1'b1;
                ctrl[CTRL_RW]       = 1'b1;
                ctrl[CTRL_DATA_MBR] = 1'b1;
                state_d = S_F4;
            end
            S_F4: begin
                ctrl[CTRL_MBR_ABUS] = 1'b1;
                ctrl[CTRL_ABUS_IR]  = 1'b1;
                ctrl[CTRL_PC_INC]   = 1'b1;
                state_d = S_DEC;
            end
            S_DEC: begin
                ctrl[CTRL_IR_ABUS]  = 1'b1;
                ctrl[CTRL_ABUS_MAR] = 1'b1;
                // Only combinational ctrl term: taken branch loads PC here.
                ctrl[CTRL_ABUS_PC]  = (ir_op == OP_BRN) && ac_sign;
                case (ir_op)
                    OP_LOAD, OP_ADD: state_d = S_RD_REQ;
                    OP_STORE:        state_d = S_ST_MBR;
                    default:         state_d = S_F1;
                endcase
            end
            S_RD_REQ: begin
                ctrl[CTRL_MAR_ADDR] = 1'b1;
                ctrl[CTRL_RW]       = 1'b1;
                ctrl[CTRL_REQ]      = 1'b1;
                state_d = expire ? S_FAULT : (mem_wait ? S_RD_REQ : S_RD_LAT);
            end
            S_RD_LAT: begin
                ctrl[CTRL_MAR_ADDR] = 1'b1;
                ctrl[CTRL_RW]       = 1'b1;
                ctrl[CTRL_DATA_MBR] = 1'b1;
                state_d = (ir_op == OP_ADD) ? S_ADD_ALU : S_LD_ALU;
            end
            S_LD_ALU: begin
                ctrl[CTRL_MBR_MBUS]  = 1'b1;
                ctrl[CTRL_MBUS_ALUB] = 1'b1;
                ctrl[CTRL_ALU_PASSB] = 1'b1;
                state_d = S_WB;
            end
            S_ADD_ALU: begin
                ctrl[CTRL_AC_ALUA]   = 1'b1;
                ctrl[CTRL_MBR_MBUS]  = 1'b1;
                ctrl[CTRL_MBUS_ALUB] = 1'b1;
                ctrl[CTRL_ALU_ADD]   = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
                ctrl[CTRL_ALU_RBUS] = 1'b1;
                ctrl[CTRL_RBUS_AC]  = 1'b1;
                state_d = S_F1;
            end
            S_ST_MBR: begin
                ctrl[CTRL_AC_RBUS]  = 1'b1;
                ctrl[CTRL_RBUS_MBR] = 1'b1;
                state_d = S_ST_REQ;
            end
            S_ST_REQ: begin
                ctrl[CTRL_MAR_ADDR] = 1'b1;
                ctrl[CTRL_MBR_DATA] = 1'b1;
                ctrl[CTRL_REQ]      = 1'b1;
                state_d = expire ? S_FAULT : (mem_wait ? S_ST_REQ : S_F1);
            end
            default: begin
                // FAULT and the unused encodings park with all controls off.
                state_d = S_FAULT;
            end
        endcase
    end

    assign state = state_q;
    assign fault = (state_q == S_FAULT);

endmodule

// File: doc/sam_sequencer.md
# sam_sequencer

Hardwired control sequencer for the SAM accumulator datapath. Drives the 22-bit control word consumed by the SAM datapath (bus gates, register loads, ALU mode, PC ops, memory RW/REQUEST) and runs fetch → decode → execute for a 4-opcode ISA. Handshakes with memory through the WAIT line. A memory stall that exceeds a programmable bound forces a sticky fault state.

## Interface
- WAIT_TIMEOUT, default 15: consecutive `mem_wait`-high cycles tolerated in one access before FAULT; 0 disables the timeout.
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- mem_wait  input  1  memory busy; 1 = hold the current access
- ir_op  input  2  IR[15:14] opcode: 00 LOAD, 01 ADD, 10 STORE, 11 BRN
- ac_sign  input  1  AC[15]
- ctrl  output  22  datapath control word; bit map below
- state  output  4  current state encoding, for debug
- instr_done  output  1  one-cycle pulse in the F1 cycle that follows a completed instruction
- fault  output  1  sticky; high while in FAULT

## Operation
- ctrl bit map:
  - 21 PC→ABUS; 20 IR→ABUS; 19 MBR→ABUS; 18 RBUS→AC
  - 17 AC→ALU_A; 16 MBUS→ALU_B; 15 ALU add; 14 ALU pass-B
  - 13 MAR→ADDRESS_BUS; 12 MBR→DATA_BUS; 11 ABUS→IR; 10 ABUS→MAR
  - 9 DATA_BUS→MBR; 8 RBUS→MBR; 7 MBR→MBUS; 6 PC←0; 5 PC+=2; 4 ABUS→PC
  - 3 RW (1 = read); 2 REQUEST; 1 AC→RBUS; 0 ALU→RBUS
- States, with encoding, asserted ctrl bits, and next state:
  - RESET_PC(0): b6 → F1
  - F1(1): b21,b10 → F2
  - F2(2): b13,b3,b2 → F2 while mem_wait, else F3
  - F3(3): b13,b3,b9 → F4
  - F4(4): b19,b11,b5 → DEC
  - DEC(5): b20,b10, plus b4 iff ir_op==11 and ac_sign. Next: 00/01 → RD_REQ; 10 → ST_MBR; 11 → F1.
  - RD_REQ(6): b13,b3,b2 → RD_REQ while mem_wait, else RD_LAT
  - RD_LAT(7): b13,b3,b9 → LD_ALU if op 00, ADD_ALU if op 01
  - LD_ALU(8): b7,b16,b14 → WB
  - ADD_ALU(9): b17,b7,b16,b15 → WB
  - WB(10): b0,b18 → F1
  - ST_MBR(11): b1,b8 → ST_REQ
  - ST_REQ(12): b13,b12,b2 (b3=0, write) → ST_REQ while mem_wait, else F1
  - FAULT(15): ctrl = 0; exits only via reset
- ctrl is decoded from the registered state. The only exception is DEC: its b4 term combines ir_op and ac_sign combinationally.
- ir_op is sampled in DEC and in RD_LAT; IR is stable from F4 onward.
- Timeout counter, width $clog2(WAIT_TIMEOUT+1):
  - counts cycles in F2/RD_REQ/ST_REQ with mem_wait=1
  - clears on any transition out of those states
  - on mem_wait=1 with count==WAIT_TIMEOUT-1, next state is FAULT instead of staying
- instr_done is registered. Set when leaving WB, ST_REQ, or DEC (op 11) into F1; cleared otherwise. It is never set by RESET_PC→F1.

## Timing
- Reset values: state=RESET_PC, ctrl=22'h000040, instr_done=0, fault=0, timeout count=0.
- Reset is honoured in any state, including mid-access. The REQUEST bit drops combinationally with state. No access is completed after reset.
- Zero-wait latencies, counted F1 to next F1:
  - LOAD 9 cycles; ADD 9 cycles
  - STORE 7 cycles; BRN 5 cycles
  - each mem_wait-high cycle adds 1 cycle per access
- Handshake: REQUEST/RW/MAR gate stay constant until the first cycle sampling mem_wait=0. The read data latch (b9) occurs in the following cycle, with REQUEST low.
- BRN taken: PC is loaded in DEC; fetch resumes from the new PC in the next F1.
- PC arithmetic, 16-bit wrap, is in the datapath; the sequencer only issues b5/b6/b4.

## Structure
- Package sam_pkg holds:
  - state enum (4-bit, encodings above)
  - localparam indices CTRL_* for all 22 ctrl bits
  - opcode constants OP_LOAD/OP_ADD/OP_STORE/OP_BRN
- Sub-module sam_wait_timer (counter + expire flag, parameter WAIT_TIMEOUT) is instantiated once. The FSM and ctrl decode live in sam_sequencer.

## Test plan
- Reset: hold rst_n=0 3 cycles → state=0, ctrl=22'h000040, fault=0. Release → F1 with ctrl=b21|b10.
- LOAD, mem_wait=0 → state trace 1,2,3,4,5,6,7,8,10,1. instr_done pulses once on the final F1.
- ADD with mem_wait high 3 cycles on the operand read → RD_REQ held 4 cycles, then b17|b7|b16|b15, then WB. Total 12 cycles.
- STORE → ST_REQ shows b13|b12|b2 with b3=0. BRN with ac_sign=1 → DEC ctrl includes b4. BRN with ac_sign=0 → b4 absent. Both return to F1 after 5 cycles.
- mem_wait stuck high in F2 with WAIT_TIMEOUT=15 → FAULT entered after 15 wait cycles, fault=1, ctrl=0. Remains there until rst_n.
- rst_n pulsed low during ST_REQ → immediate state=0, REQUEST=0, instr_done stays 0.
